// File: rtl/camera_capture.sv
// Camera byte-stream capture: RGB565 pairs in, RGB888 pixels out to two SDRAM
// write ports, gated by a start/stop FSM that only engages on frame boundaries.
module camera_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [7:0]  iDATA,
  input  logic        iFVAL,
  input  logic        iLVAL,
  input  logic        iSTART,
  input  logic        iEND,
  output logic [15:0] oWR1_DATA,
  output logic [15:0] oWR2_DATA,
  output logic        oDVAL,
  output logic [12:0] oX_Cont,
  output logic [12:0] oY_Cont,
  output logic [15:0] oFrame_Cont,
  output logic        oBUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_ACTIVE
  } state_e;

  localparam logic [12:0] XY_MAX = 13'h1FFF;
  localparam logic [31:0] H_LIM  = 32'(H_ACTIVE);
  localparam logic [31:0] V_LIM  = 32'(V_ACTIVE);

  logic [1:0]  rst_sync_q, rst_sync_d;
  logic        rst_n;

  logic [7:0]  data_q;
  logic        fval_q, lval_q;
  logic        fval_p_q, lval_p_q;
  state_e      state_q, state_d;
  logic        end_pend_q, end_pend_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [12:0] x_q, x_d;
  logic [12:0] y_q, y_d;
  logic [12:0] xd_q, yd_q;
  logic [15:0] pix_q, pix_d;
  logic        pix_vld_q, pix_vld_d;
  logic [15:0] frame_q, frame_d;
  logic        busy_q, busy_d;
  logic        dval_q;
  logic [15:0] wr1_q, wr1_d;
  logic [15:0] wr2_q, wr2_d;
  logic [12:0] ox_q, oy_q;

  logic        fval_rise, fval_fall, lval_fall;
  logic        active, take, lo, in_win;
  logic [7:0]  r8, g8, b8;

  // Release is re-timed to iCLK; assertion still clears everything at once.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) rst_sync_q <= 2'b00;
    else         rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  always_comb begin
    fval_rise = fval_q & ~fval_p_q;
    fval_fall = ~fval_q & fval_p_q;
    lval_fall = ~lval_q & lval_p_q;
    active    = (state_q == S_ACTIVE);
    take      = active & fval_q & lval_q;
    lo        = take & phase_q;
    in_win    = ({19'd0, x_q} < H_LIM) && ({19'd0, y_q} < V_LIM);
  end

  always_comb begin
    state_d    = state_q;
    end_pend_d = end_pend_q;
    unique case (state_q)
      S_IDLE: begin
        end_pend_d = 1'b0;
        if (iSTART && !iEND) state_d = S_ARMED;
      end
      S_ARMED: begin
        end_pend_d = 1'b0;
        if (iEND)           state_d = S_IDLE;
        else if (fval_rise) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (fval_fall && end_pend_q) begin
          state_d    = S_IDLE;
          end_pend_d = 1'b0;
        end else if (iEND) begin
          end_pend_d = 1'b1;
        end else if (iSTART) begin
          end_pend_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        end_pend_d = 1'b0;
      end
    endcase
    busy_d = (state_d == S_ACTIVE);
  end

  always_comb begin
    phase_d = phase_q;
    if (!lval_q)   phase_d = 1'b0;
    else if (take) phase_d = ~phase_q;

    hi_d      = (take && !phase_q) ? data_q : hi_q;
    pix_d     = lo ? {hi_q, data_q} : pix_q;
    pix_vld_d = lo & in_win;

    x_d = x_q;
    if (lval_fall)                x_d = 13'd0;
    else if (lo && x_q != XY_MAX) x_d = x_q + 13'd1;

    y_d = y_q;
    if (fval_rise && state_q != S_IDLE)
      y_d = 13'd0;
    else if (lval_fall && active && y_q != XY_MAX)
      y_d = y_q + 13'd1;

    frame_d = (fval_fall && active) ? frame_q + 16'd1 : frame_q;
  end

  always_comb begin
    r8    = {pix_q[15:11], pix_q[15:13]};
    g8    = {pix_q[10:5], pix_q[10:9]};
    b8    = {pix_q[4:0], pix_q[4:2]};
    wr1_d = pix_vld_q ? {r8, g8} : wr1_q;
    wr2_d = pix_vld_q ? {b8, 8'h00} : wr2_q;
  end

  always_ff @(posedge iCLK or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      fval_q     <= 1'b0;
      lval_q     <= 1'b0;
      fval_p_q   <= 1'b0;
      lval_p_q   <= 1'b0;
      state_q    <= S_IDLE;
      end_pend_q <= 1'b0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      xd_q       <= '0;
      yd_q       <= '0;
      pix_q      <= '0;
      pix_vld_q  <= 1'b0;
      frame_q    <= '0;
      busy_q     <= 1'b0;
      dval_q     <= 1'b0;
      wr1_q      <= '0;
      wr2_q      <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
    end else begin
      data_q     <= iDATA;
      fval_q     <= iFVAL;
      lval_q     <= iLVAL;
      fval_p_q   <= fval_q;
      lval_p_q   <= lval_q;
      state_q    <= state_d;
      end_pend_q <= end_pend_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      x_q        <= x_d;
      y_q        <= y_d;
      xd_q       <= x_q;
      yd_q       <= y_q;
      pix_q      <= pix_d;
      pix_vld_q  <= pix_vld_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
      dval_q     <= pix_vld_q;
      wr1_q      <= wr1_d;
      wr2_q      <= wr2_d;
      ox_q       <= xd_q;
      oy_q       <= yd_q;
    end
  end

  assign oWR1_DATA   = wr1_q;
  assign oWR2_DATA   = wr2_q;
  assign oDVAL       = dval_q;
  assign oX_Cont     = ox_q;
  assign oY_Cont     = oy_q;
  assign oFrame_Cont = frame_q;
  assign oBUSY       = busy_q;

endmodule

// File: doc/camera_capture.md
CAMERA_CAPTURE -- requirements
Module: camera_capture

Interface
REQ-001 The block SHALL have the parameter H_ACTIVE, default 640, meaning pixels per line accepted into the write stream.
REQ-002 The block SHALL have the parameter V_ACTIVE, default 480, meaning lines per frame accepted into the write stream.
REQ-003 The block SHALL have port iCLK, input, 1 bit: camera pixel clock, and the only clock; all logic is on its rising edge.
REQ-004 The block SHALL have port iRST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port iDATA, input, 8 bits: camera byte bus carrying RGB565, high byte first.
REQ-006 The block SHALL have port iFVAL, input, 1 bit: frame valid.
REQ-007 The block SHALL have port iLVAL, input, 1 bit: line valid.
REQ-008 The block SHALL have port iSTART, input, 1 bit: single-cycle pulse requesting capture on.
REQ-009 The block SHALL have port iEND, input, 1 bit: single-cycle pulse requesting capture off.
REQ-010 The block SHALL have port oWR1_DATA, output, 16 bits: {R8,G8} for SDRAM write port 1.
REQ-011 The block SHALL have port oWR2_DATA, output, 16 bits: {B8,8'h00} for SDRAM write port 2.
REQ-012 The block SHALL have port oDVAL, output, 1 bit: write strobe, one pulse per accepted pixel.
REQ-013 The block SHALL have port oX_Cont, output, 13 bits: pixel index within the line.
REQ-014 The block SHALL have port oY_Cont, output, 13 bits: line index within the frame.
REQ-015 The block SHALL have port oFrame_Cont, output, 16 bits: count of completed captured frames.
REQ-016 The block SHALL have port oBUSY, output, 1 bit: high while state is ACTIVE.

Function
REQ-017 iDATA, iFVAL and iLVAL SHALL be registered once on entry, and all edge detection SHALL use the registered values and their previous-cycle copies.
REQ-018 The FSM SHALL have exactly three states: IDLE, ARMED and ACTIVE.
REQ-019 IDLE SHALL go to ARMED on iSTART.
REQ-020 ARMED SHALL go to ACTIVE on a registered iFVAL rising edge, so capture begins only at a frame start.
REQ-021 ACTIVE SHALL go to IDLE on a registered iFVAL falling edge if an iEND has been latched since entering ACTIVE; otherwise ACTIVE SHALL persist.
REQ-022 iEND in ARMED SHALL return the FSM to IDLE immediately.
REQ-023 iSTART and iEND in the same cycle SHALL be treated as iEND.
REQ-024 iSTART received while ACTIVE SHALL clear any pending iEND.
REQ-025 A byte phase bit SHALL toggle on each registered cycle with iLVAL&iFVAL high in ACTIVE, and SHALL clear to 0 whenever registered iLVAL is low.
REQ-026 On phase 0 the byte SHALL be held as the high byte; on phase 1 the pixel SHALL be {high,iDATA}.
REQ-027 An odd trailing byte at line end SHALL be discarded.
REQ-028 Colour expansion SHALL be R8={R5,R5[4:2]}, G8={G6,G6[5:4]} and B8={B5,B5[4:2]}.
REQ-029 oDVAL SHALL assert for exactly one cycle, two iCLK edges after the edge that registers the low byte, with oWR1_DATA, oWR2_DATA, oX_Cont and oY_Cont valid in the same cycle.
REQ-030 oDVAL SHALL assert only when the pixel's X<H_ACTIVE and Y<V_ACTIVE; excess pixels and lines SHALL be counted but not strobed.
REQ-031 oX_Cont SHALL increment by 1 after each assembled pixel and SHALL clear on a registered iLVAL falling edge.
REQ-032 oY_Cont SHALL increment on a registered iLVAL falling edge while in ACTIVE, and SHALL clear on a registered iFVAL rising edge.
REQ-033 Both oX_Cont and oY_Cont SHALL saturate at 8191 with no wrap.
REQ-034 oFrame_Cont SHALL increment on every registered iFVAL falling edge in ACTIVE, including the terminating frame, and SHALL wrap from 16'hFFFF to 0.
REQ-035 A frame in progress when ARMED is entered SHALL be ignored entirely: no oDVAL and no counting.
REQ-036 oWR1_DATA and oWR2_DATA SHALL hold their last value while oDVAL is low.

Reset
REQ-037 While iRST_N=0, all outputs and state SHALL be 0, and the FSM SHALL be in IDLE with no pending iEND.
REQ-038 Reset asserted mid-line SHALL abort the pixel immediately, and after release capture SHALL require a new iSTART.
REQ-039 Reset deassertion SHALL be applied synchronously to iCLK inside the block; assertion SHALL remain asynchronous.

Verification
REQ-040 The bench SHALL pulse iSTART, then drive a 4-line frame of 8 bytes/line, first pixel bytes 8'hF8,8'h00 -> 4 oDVAL/line, 16 total, first oWR1_DATA=16'hFF00 and oWR2_DATA=16'h0000 at X=0,Y=0, then oFrame_Cont=1.
REQ-041 The bench SHALL pulse iSTART mid-frame -> zero oDVAL in that frame, and capture SHALL start at the next iFVAL rise with oY_Cont=0.
REQ-042 With H_ACTIVE=2, V_ACTIVE=2, the bench SHALL send 3 lines of 3 pixels -> exactly 4 oDVAL, and oX_Cont SHALL reach 3 while oY_Cont reaches 3.
REQ-043 The bench SHALL send a line of 7 bytes -> 3 oDVAL, with the next line starting at phase 0 and X=0.
REQ-044 The bench SHALL pulse iEND mid-frame -> the frame completes, oFrame_Cont increments, oBUSY falls at iFVAL fall, and the next frame produces zero oDVAL.
REQ-045 The bench SHALL assert iRST_N low for 1 cycle mid-line -> all outputs 0 within the same cycle, and no oDVAL until a new iSTART and iFVAL rise.
